cs_dac_i2s_tx: RTL and testbench
================================

// Module: cs_dac_i2s_tx
// PURPOSE
// - I2S transmitter feeding the Cirrus DAC. Consumes the mixer's stereo DAC stream (cs_dac_*: data/valid/ready/last).
// - Generates SCLK/LRCK from clk and serialises 24-bit samples, MSB first, in standard I2S framing.
// - frame_strobe marks each frame load; it is the sample-rate timebase for the audio path.
// PARAMETERS
// - AUDIO_WIDTH_P  24  sample width; must be <= SLOT_WIDTH_P-1
// - SLOT_WIDTH_P   32  SCLK periods per channel slot (frame = 2*SLOT_WIDTH_P)
// - SCLK_HALF_P    2   clk cycles per SCLK half period (>=1)
// PORTS
// - clk                  in   1   system clock
// - rst_n                in   1   asynchronous active-low reset
// - cs_dac_data          in   AUDIO_WIDTH_P  signed sample
// - cs_dac_valid         in   1   sample valid
// - cs_dac_ready         out  1   sample accepted when valid&&ready
// - cs_dac_last          in   1   0=left sample, 1=right sample
// - i2s_sclk             out  1   bit clock
// - i2s_lrck             out  1   word select, 0=left, 1=right
// - i2s_sdata            out  1   serial data, changes on SCLK falling edge
// - frame_strobe         out  1   1-cycle pulse when a frame is loaded
// - cmd_clear_status     in   1   clears sticky status flags
// - sr_underflow         out  1   sticky: frame loaded with no full pair
// - sr_align_err         out  1   sticky: last=1 received in left slot
// BEHAVIOUR
// - Reset values: cs_dac_ready=0, i2s_sclk=0, i2s_lrck=0, i2s_sdata=0, frame_strobe=0, sr_*=0.
// - Internal reset state: div_cnt=0, bit_cnt=2*SLOT_WIDTH_P-1, pair state WAIT_LEFT, shift regs 0.
// - Divider: div_cnt counts 0..SCLK_HALF_P-1; i2s_sclk toggles on wrap. The first toggle after reset is rising.
// - On each SCLK falling toggle, bit_cnt increments modulo 2*SLOT_WIDTH_P.
// - i2s_lrck <= (new bit_cnt >= SLOT_WIDTH_P), registered on the same edge.
// - Data: with s = new bit_cnt mod SLOT_WIDTH_P, i2s_sdata <= sample bit [AUDIO_WIDTH_P-s] for 1<=s<=AUDIO_WIDTH_P, else 0.
//   - This gives the one-SCLK I2S delay after the LRCK edge.
//   - Left word while lrck=0, right word while lrck=1.
// - Load event: the falling edge where bit_cnt wraps to 0. frame_strobe pulses that cycle.
//   - First load occurs at the first falling edge after reset.
// - Pair FSM (WAIT_LEFT, WAIT_RIGHT, FULL):
//   - cs_dac_ready=1 in WAIT_LEFT/WAIT_RIGHT (registered, asserted 1 cycle after reset release); 0 in FULL.
//   - WAIT_LEFT + beat(last=0): store left, go to WAIT_RIGHT.
//   - WAIT_LEFT + beat(last=1): discard, set sr_align_err, stay in WAIT_LEFT.
//   - WAIT_RIGHT + beat(last=1): store right, go to FULL.
//   - WAIT_RIGHT + beat(last=0): overwrite left, set sr_align_err, stay in WAIT_RIGHT.
//   - Load in FULL: copy the pair into the shift regs, go to WAIT_LEFT.
//   - Load in any other state: shift regs load 0 (silence), set sr_underflow, FSM and holding regs unchanged.
//   - Load coincident with an accepted beat (WAIT_RIGHT->FULL in the same cycle): the beat is stored; the load still sees the pre-beat state and counts as underflow.
// - Status: cmd_clear_status clears both flags. A set in the same cycle as a clear wins.
// - Reset mid-frame: immediate, all state returns to reset values; the partial pair is dropped.
// - Throughput: one frame per 4*SLOT_WIDTH_P*SCLK_HALF_P clk cycles (256 at defaults).
// STRUCTURE
// - dafx_pkg holds:
//   - AUDIO_WIDTH_C, I2S_SLOT_WIDTH_C, I2S_SCLK_HALF_C constants.
//   - typedef enum {WAIT_LEFT, WAIT_RIGHT, FULL} i2s_pair_state_t.
// - Sub-module i2s_sclk_gen:
//   - Divider plus bit counter.
//   - Outputs i2s_sclk, sclk_fall pulse, bit_cnt, frame_load pulse.
// - Top level holds the pair FSM, holding regs, shift regs and status.
// TESTING
// - Reset release, no input:
//   - sdata stays 0; sr_underflow=1 after the first frame_strobe.
//   - cs_dac_ready=1 from cycle 2.
// - Pair in sequence, then left=24'hABCDEF, right=24'h123456:
//   - Left slot bits 1..24 read AB CD EF MSB first, bits 25..31 are 0, lrck=0.
//   - Right slot carries 12 34 56 with lrck=1.
// - Backpressure: send 3 pairs back to back.
//   - cs_dac_ready drops after each right beat and rises 1 cycle after each frame_strobe.
//   - No underflow, no lost or reordered samples.
// - Beat with last=1 first:
//   - sr_align_err=1; the sample is not output; the next valid pair plays correctly.
//   - cmd_clear_status returns the flag to 0.
// - Right beat accepted in the same cycle as the load:
//   - sr_underflow=1 and a silent frame is sent.
//   - The next frame carries that pair.
// - Assert rst_n mid right slot:
//   - All outputs read 0 within 1 cycle.
//   - After release, framing restarts at the first load.

Source files
------------

// File: rtl/dafx_pkg.sv
// Shared constants and types for the DAC audio path.
package dafx_pkg;

  localparam int AUDIO_WIDTH_C    = 24;
  localparam int I2S_SLOT_WIDTH_C = 32;
  localparam int I2S_SCLK_HALF_C  = 2;

  typedef enum logic [1:0] {
    WAIT_LEFT,
    WAIT_RIGHT,
    FULL
  } i2s_pair_state_t;

  // Width of a counter spanning one full stereo frame of SCLK periods.
  function automatic int bit_cnt_width(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock divider and frame bit counter; flags the SCLK falling edge
// and the falling edge that starts a new frame.
module i2s_sclk_gen import dafx_pkg::*; #(
  parameter int  SLOT_WIDTH_P = I2S_SLOT_WIDTH_C,
  parameter int  SCLK_HALF_P  = I2S_SCLK_HALF_C,
  localparam int BIT_W        = bit_cnt_width(SLOT_WIDTH_P)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             i2s_sclk,
  output logic             sclk_fall,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             frame_load
);

  localparam int DIV_W      = (SCLK_HALF_P > 1) ? $clog2(SCLK_HALF_P) : 1;
  localparam int FRAME_LAST = 2 * SLOT_WIDTH_P - 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign div_wrap   = (div_cnt == DIV_W'(SCLK_HALF_P - 1));
  // The registered SCLK falls at the end of this cycle.
  assign sclk_fall  = div_wrap && i2s_sclk;
  assign frame_load = sclk_fall && (bit_cnt == BIT_W'(FRAME_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_sclk <= 1'b0;
      bit_cnt  <= BIT_W'(FRAME_LAST);
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) i2s_sclk <= ~i2s_sclk;
      if (sclk_fall) bit_cnt <= frame_load ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cs_dac_i2s_tx.sv
// I2S transmitter for the Cirrus DAC: pairs left/right beats from the mixer
// stream and serialises them MSB first with the standard one-SCLK delay.
module cs_dac_i2s_tx import dafx_pkg::*; #(
  parameter int AUDIO_WIDTH_P = AUDIO_WIDTH_C,
  parameter int SLOT_WIDTH_P  = I2S_SLOT_WIDTH_C,
  parameter int SCLK_HALF_P   = I2S_SCLK_HALF_C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_P-1:0] cs_dac_data,
  input  logic                     cs_dac_valid,
  output logic                     cs_dac_ready,
  input  logic                     cs_dac_last,
  output logic                     i2s_sclk,
  output logic                     i2s_lrck,
  output logic                     i2s_sdata,
  output logic                     frame_strobe,
  input  logic                     cmd_clear_status,
  output logic                     sr_underflow,
  output logic                     sr_align_err
);

  localparam int BIT_W = bit_cnt_width(SLOT_WIDTH_P);
  localparam int IDX_W = $clog2(AUDIO_WIDTH_P);

  i2s_pair_state_t          state;
  logic [AUDIO_WIDTH_P-1:0] hold_left, hold_right;
  logic [AUDIO_WIDTH_P-1:0] tx_left, tx_right;
  logic                     sclk_fall, frame_load;
  logic [BIT_W-1:0]         bit_cnt, bit_nxt, slot_pos;
  logic [IDX_W-1:0]         bit_idx;
  logic                     lrck_nxt, sdata_nxt;
  logic                     beat, to_full, underflow_set, align_set;

  i2s_sclk_gen #(
    .SLOT_WIDTH_P (SLOT_WIDTH_P),
    .SCLK_HALF_P  (SCLK_HALF_P)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2s_sclk   (i2s_sclk),
    .sclk_fall  (sclk_fall),
    .bit_cnt    (bit_cnt),
    .frame_load (frame_load)
  );

  assign frame_strobe  = frame_load;
  assign beat          = cs_dac_valid && cs_dac_ready;
  // A load sees the pre-beat state, so a right beat landing on it still underflows.
  assign underflow_set = frame_load && (state != FULL);
  assign align_set     = beat && (((state == WAIT_LEFT) && cs_dac_last) ||
                                  ((state == WAIT_RIGHT) && !cs_dac_last));
  assign to_full       = ((state == WAIT_RIGHT) && beat && cs_dac_last) ||
                         ((state == FULL) && !frame_load);

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    bit_nxt   = frame_load ? '0 : bit_cnt + 1'b1;
    lrck_nxt  = (bit_nxt >= BIT_W'(SLOT_WIDTH_P));
    slot_pos  = lrck_nxt ? bit_nxt - BIT_W'(SLOT_WIDTH_P) : bit_nxt;
    bit_idx   = '0;
    sdata_nxt = 1'b0;
    // Slot position 0 is the I2S delay bit; positions past the sample are padding.
    if ((slot_pos != '0) && (slot_pos <= BIT_W'(AUDIO_WIDTH_P))) begin
      bit_idx   = IDX_W'(AUDIO_WIDTH_P - int'(slot_pos));
      sdata_nxt = lrck_nxt ? tx_right[bit_idx] : tx_left[bit_idx];
    end
  end

  // NOTE: holding and shift registers are reset as well, so a reset mid-frame
  // drops the partial pair and the restarted stream begins in silence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LEFT;
      hold_left    <= '0;
      hold_right   <= '0;
      tx_left      <= '0;
      tx_right     <= '0;
      cs_dac_ready <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      sr_underflow <= 1'b0;
      sr_align_err <= 1'b0;
    end else begin
      if (sclk_fall) begin
        i2s_lrck  <= lrck_nxt;
        i2s_sdata <= sdata_nxt;
      end

      if (frame_load) begin
        tx_left  <= (state == FULL) ? hold_left  : '0;
        tx_right <= (state == FULL) ? hold_right : '0;
      end

      case (state)
        WAIT_LEFT: begin
          if (beat && !cs_dac_last) begin
            hold_left <= cs_dac_data;
            state     <= WAIT_RIGHT;
          end
        end
        WAIT_RIGHT: begin
          if (beat && cs_dac_last) begin
            hold_right <= cs_dac_data;
            state      <= FULL;
          end else if (beat) begin
            hold_left <= cs_dac_data;
          end
        end
        FULL: begin
          if (frame_load) state <= WAIT_LEFT;
        end
        default: state <= WAIT_LEFT;
      endcase

      cs_dac_ready <= !to_full;
      sr_underflow <= underflow_set || (sr_underflow && !cmd_clear_status);
      sr_align_err <= align_set || (sr_align_err && !cmd_clear_status);
    end
  end

endmodule

// File: tb/tb_cs_dac_i2s_tx.sv
// Self-checking bench for cs_dac_i2s_tx: a frame-level reference model queues
// the expected serial frames, and a monitor deserialises the I2S pins to compare.
module tb_cs_dac_i2s_tx;
  import dafx_pkg::*;

  localparam int AW         = AUDIO_WIDTH_C;
  localparam int SW         = I2S_SLOT_WIDTH_C;
  localparam int FRAME_BITS = 2 * SW;
  localparam logic [63:0] LRCK_PATTERN = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cs_dac_data = '0;
  logic          cs_dac_valid = 1'b0;
  logic          cs_dac_ready;
  logic          cs_dac_last = 1'b0;
  logic          i2s_sclk, i2s_lrck, i2s_sdata, frame_strobe;
  logic          cmd_clear_status = 1'b0;
  logic          sr_underflow, sr_align_err;

  always #5 clk = ~clk;

  cs_dac_i2s_tx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cs_dac_data      (cs_dac_data),
    .cs_dac_valid     (cs_dac_valid),
    .cs_dac_ready     (cs_dac_ready),
    .cs_dac_last      (cs_dac_last),
    .i2s_sclk         (i2s_sclk),
    .i2s_lrck         (i2s_lrck),
    .i2s_sdata        (i2s_sdata),
    .frame_strobe     (frame_strobe),
    .cmd_clear_status (cmd_clear_status),
    .sr_underflow     (sr_underflow),
    .sr_align_err     (sr_align_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: event not seen within its bound at %0t", name, $time);
  endtask

  // Expected 64-bit serial frame: delay bit, sample MSB first, zero padding, per slot.
  function automatic logic [63:0] frame_bits(input logic [AW-1:0] l, input logic [AW-1:0] r);
    return {1'b0, l, {(SW-1-AW){1'b0}}, 1'b0, r, {(SW-1-AW){1'b0}}};
  endfunction

  // ---------------- reference model (frame level) ----------------
  logic [63:0]   exp_q[$];
  int unsigned   posedges_since_rst;
  bit            m_have_left, m_full, m_uf, m_al, uf_set, al_set;
  logic [AW-1:0] m_left, m_right;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) posedges_since_rst <= 0;
    else if (posedges_since_rst < 4) posedges_since_rst <= posedges_since_rst + 1;
  end

  // Each negedge: compare DUT status with the model, then apply what the
  // coming posedge will do (strobe = load on that edge, beat = handshake on it).
  always @(negedge clk) begin
    if (!rst_n) begin
      m_have_left = 0; m_full = 0; m_uf = 0; m_al = 0;
      m_left = '0; m_right = '0;
      exp_q.delete();
    end else begin
      check("ready", cs_dac_ready, (posedges_since_rst >= 1) && !m_full);
      check("sr_underflow", sr_underflow, m_uf);
      check("sr_align_err", sr_align_err, m_al);
      uf_set = 0;
      al_set = 0;
      if (frame_strobe) begin
        if (m_full) begin
          exp_q.push_back(frame_bits(m_left, m_right));
          m_full = 0;
          m_have_left = 0;
        end else begin
          exp_q.push_back(frame_bits('0, '0));
          uf_set = 1;
        end
      end
      if (cs_dac_valid && cs_dac_ready && !m_full) begin
        if (!m_have_left) begin
          if (cs_dac_last) al_set = 1;
          else begin m_left = cs_dac_data; m_have_left = 1; end
        end else if (cs_dac_last) begin
          m_right = cs_dac_data;
          m_full = 1;
        end else begin
          m_left = cs_dac_data;
          al_set = 1;
        end
      end
      m_uf = uf_set || (m_uf && !cmd_clear_status);
      m_al = al_set || (m_al && !cmd_clear_status);
    end
  end

  // ---------------- monitor: deserialise on SCLK rising edges ----------------
  int          mon_k = -1;
  int          frames_checked = 0;
  bit          prev_sclk = 0;
  logic [63:0] got_d, got_lr, exp_frame;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_k = -1;
      prev_sclk = 0;
    end else begin
      if (frame_strobe) begin
        mon_k = 0;
        got_d = '0;
        got_lr = '0;
      end else if (i2s_sclk && !prev_sclk && mon_k >= 0 && mon_k < FRAME_BITS) begin
        got_d[FRAME_BITS-1-mon_k]  = i2s_sdata;
        got_lr[FRAME_BITS-1-mon_k] = i2s_lrck;
        mon_k++;
        if (mon_k == FRAME_BITS) begin
          if (exp_q.size() == 0) note_fail("frame_unexpected");
          else begin
            exp_frame = exp_q.pop_front();
            check("frame_sdata", got_d, exp_frame);
            check("frame_lrck", got_lr, LRCK_PATTERN);
            frames_checked++;
          end
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [AW-1:0] d, input logic last);
    bit ok;
    ok = 0;
    cs_dac_data = d;
    cs_dac_last = last;
    cs_dac_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs_dac_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cs_dac_valid = 1'b0;
    if (!ok) note_fail("send_beat_timeout");
  endtask

  task automatic send_pair(input logic [AW-1:0] l, input logic [AW-1:0] r);
    send_beat(l, 1'b0);
    send_beat(r, 1'b1);
  endtask

  task automatic wait_strobe();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_strobe) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) note_fail("wait_strobe_timeout");
  endtask

  task automatic pulse_clear();
    cmd_clear_status = 1'b1;
    @(posedge clk); #1;
    cmd_clear_status = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_sample();
    return AW'($urandom);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset: silent frames, underflow latched.
    cycles(300);
    check("idle_underflow", sr_underflow, 1'b1);
    check("idle_ready", cs_dac_ready, 1'b1);

    // Directed pair.
    pulse_clear();
    send_pair(24'hABCDEF, 24'h123456);
    cycles(600);

    // Three pairs back to back right after a load.
    wait_strobe();
    pulse_clear();
    for (int i = 0; i < 3; i++) send_pair(rnd_sample(), rnd_sample());
    check("b2b_no_underflow", sr_underflow, 1'b0);
    wait_strobe();
    check("b2b_no_underflow_after_load", sr_underflow, 1'b0);
    cycles(300);

    // Misaligned right beat first, then a clean pair, then clear.
    wait_strobe();
    pulse_clear();
    send_beat(rnd_sample(), 1'b1);
    check("align_set", sr_align_err, 1'b1);
    send_pair(rnd_sample(), rnd_sample());
    cycles(600);
    check("align_sticky", sr_align_err, 1'b1);
    pulse_clear();
    check("align_cleared", sr_align_err, 1'b0);
    cycles(300);

    // Right beat accepted on the same edge as the load.
    wait_strobe();
    cmd_clear_status = 1'b1;
    cs_dac_data = rnd_sample();
    cs_dac_last = 1'b0;
    cs_dac_valid = 1'b1;
    @(posedge clk); #1;
    cs_dac_valid = 1'b0;
    cmd_clear_status = 1'b0;
    cycles(254);
    cs_dac_data = rnd_sample();
    cs_dac_last = 1'b1;
    cs_dac_valid = 1'b1;
    @(negedge clk);
    check("coincident_strobe", frame_strobe, 1'b1);
    check("coincident_ready", cs_dac_ready, 1'b1);
    @(posedge clk); #1;
    cs_dac_valid = 1'b0;
    check("coincident_underflow", sr_underflow, 1'b1);
    check("coincident_full", cs_dac_ready, 1'b0);
    cycles(600);

    // Reset asserted in the right slot of a playing frame.
    send_beat(rnd_sample(), 1'b1);
    send_pair(rnd_sample(), rnd_sample());
    wait_strobe();
    cycles(150);
    rst_n = 1'b0;
    #1;
    check("rst_ready", cs_dac_ready, 1'b0);
    check("rst_sclk", i2s_sclk, 1'b0);
    check("rst_lrck", i2s_lrck, 1'b0);
    check("rst_sdata", i2s_sdata, 1'b0);
    check("rst_strobe", frame_strobe, 1'b0);
    check("rst_underflow", sr_underflow, 1'b0);
    check("rst_align", sr_align_err, 1'b0);
    cycles(3);
    @(posedge clk); #3;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_strobe) break;
      n++;
    end
    check("restart_first_load", n, 3);
    @(posedge clk); #1;

    // Randomised traffic with stray beats, overwrites and clears.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) send_beat(rnd_sample(), 1'b1);
      if ($urandom_range(0, 7) == 0) pulse_clear();
      send_beat(rnd_sample(), 1'b0);
      if ($urandom_range(0, 5) == 0) send_beat(rnd_sample(), 1'b0);
      send_beat(rnd_sample(), 1'b1);
      cycles($urandom_range(0, 300));
    end
    cycles(700);
    check("frames_checked", frames_checked >= 30, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
